// File: rtl/alu_exec_ctrl_if.sv
// Bus between the execute-stage controller and its neighbours: instruction
// stream in, ALU operand/opcode/result bus, result stream out, and status flags.
interface alu_exec_ctrl_if;
  logic [7:0] instr;
  logic       instrValid;
  logic       instrReady;
  logic [2:0] aluOpcode;
  logic [7:0] aluOperandA;
  logic [7:0] aluOperandB;
  logic [7:0] aluResult;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic       zero;
  logic       negative;
  logic       illegal;

  modport master (
    input  instr, instrValid, aluResult, outReady,
    output instrReady, aluOpcode, aluOperandA, aluOperandB,
           outData, outValid, zero, negative, illegal
  );

  modport slave (
    output instr, instrValid, aluResult, outReady,
    input  instrReady, aluOpcode, aluOperandA, aluOperandB,
           outData, outValid, zero, negative, illegal
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: decodes instruction bytes, owns operand registers
// A/B, drives the 8-bit ALU and writes its result back into A with flags.
module alu_exec_ctrl (
  input  logic            clock,
  input  logic            resetN,
  alu_exec_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_IMM,
    ST_EXEC,
    ST_OUT
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] out_data_q, out_data_d;
  logic [2:0] opcode_q, opcode_d;
  logic       dest_q, dest_d;
  logic       zero_q, zero_d;
  logic       negative_q, negative_d;
  logic       illegal_q, illegal_d;

  logic       instr_ready;
  logic       accept;
  logic [1:0] mode;
  logic       instr_legal;

  // Handshake outputs depend only on state (and reset), never on valid/ready inputs.
  always_comb begin
    instr_ready = resetN && ((state_q == ST_FETCH) || (state_q == ST_IMM));
  end

  assign accept = instr_ready && bus.instrValid;
  assign mode   = bus.instr[7:6];

  always_comb begin
    instr_legal = 1'b0;
    unique case (mode)
      2'b00:   instr_legal = (bus.instr[5:1] == 5'b00000);
      2'b01:   instr_legal = (bus.instr[5:3] == 3'b000) && (bus.instr[2:1] != 2'b11);
      default: instr_legal = (bus.instr[5:0] == 6'b000000);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    out_data_d = out_data_q;
    opcode_d   = opcode_q;
    dest_d     = dest_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    illegal_d  = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (accept) begin
          if (!instr_legal) begin
            illegal_d = 1'b1;
          end else begin
            unique case (mode)
              2'b00: begin
                dest_d  = bus.instr[0];
                state_d = ST_IMM;
              end
              2'b01: begin
                opcode_d = bus.instr[2:0];
                state_d  = ST_EXEC;
              end
              2'b10: begin
                out_data_d = a_q;
                state_d    = ST_OUT;
              end
              default: ;
            endcase
          end
        end
      end
      ST_IMM: begin
        if (accept) begin
          if (dest_q) b_d = bus.instr;
          else        a_d = bus.instr;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        a_d        = bus.aluResult;
        zero_d     = (bus.aluResult == 8'h00);
        negative_d = bus.aluResult[7];
        state_d    = ST_FETCH;
      end
      ST_OUT: begin
        if (bus.outReady) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= ST_FETCH;
      a_q        <= '0;
      b_q        <= '0;
      out_data_q <= '0;
      opcode_q   <= '0;
      dest_q     <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_data_q <= out_data_d;
      opcode_q   <= opcode_d;
      dest_q     <= dest_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.instrReady  = instr_ready;
  assign bus.outValid    = (state_q == ST_OUT);
  assign bus.outData     = out_data_q;
  assign bus.aluOpcode   = opcode_q;
  assign bus.aluOperandA = a_q;
  assign bus.aluOperandB = b_q;
  assign bus.zero        = zero_q;
  assign bus.negative    = negative_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed program sequences with literal
// expectations, then randomized traffic against an instruction-level model.
module tb_alu_exec_ctrl;

  logic clock;
  logic resetN;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a + b;
      3'd5:    return a - b;
      default: return 8'h00;
    endcase
  endfunction

  // The downstream ALU itself, modelled as pure combinational logic.
  assign bus.aluResult = alu_f(bus.aluOpcode, bus.aluOperandA, bus.aluOperandB);

  logic [7:0] legal_tab [10] = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h80, 8'hC0};

  function automatic bit is_legal(input logic [7:0] i);
    return i inside {8'h00, 8'h01, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h80, 8'hC0};
  endfunction

  // Instruction-level model: registers plus what the block is waiting for.
  logic [7:0] m_a, m_b, m_out;
  logic [2:0] m_op;
  bit         m_zero, m_neg, m_ill, m_dest;
  bit         m_wait_imm, m_wait_exec, m_wait_out;

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_out = 8'h00; m_op = 3'd0;
    m_zero = 0; m_neg = 0; m_ill = 0; m_dest = 0;
    m_wait_imm = 0; m_wait_exec = 0; m_wait_out = 0;
  endtask

  task automatic model_edge(input bit rst_n, input bit vld, input logic [7:0] ins, input bit ordy);
    logic [7:0] r;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_ill = 0;
      if (m_wait_exec) begin
        r = alu_f(m_op, m_a, m_b);
        m_a = r; m_zero = (r == 8'h00); m_neg = r[7];
        m_wait_exec = 0;
      end else if (m_wait_out) begin
        if (ordy) m_wait_out = 0;
      end else if (vld) begin
        if (m_wait_imm) begin
          if (m_dest) m_b = ins; else m_a = ins;
          m_wait_imm = 0;
        end else if (!is_legal(ins)) begin
          m_ill = 1;
        end else if (ins[7:6] == 2'b00) begin
          m_dest = ins[0]; m_wait_imm = 1;
        end else if (ins[7:6] == 2'b01) begin
          m_op = ins[2:0]; m_wait_exec = 1;
        end else if (ins[7:6] == 2'b10) begin
          m_out = m_a; m_wait_out = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("instrReady", {7'b0, bus.instrReady}, {7'b0, resetN && !m_wait_exec && !m_wait_out});
    chk("outValid",   {7'b0, bus.outValid},   {7'b0, m_wait_out});
    chk("outData",    bus.outData,            m_out);
    chk("aluOperandA", bus.aluOperandA,       m_a);
    chk("aluOperandB", bus.aluOperandB,       m_b);
    chk("aluOpcode",  {5'b0, bus.aluOpcode},  {5'b0, m_op});
    chk("zero",       {7'b0, bus.zero},       {7'b0, m_zero});
    chk("negative",   {7'b0, bus.negative},   {7'b0, m_neg});
    chk("illegal",    {7'b0, bus.illegal},    {7'b0, m_ill});
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input bit rst_n, input bit vld, input logic [7:0] ins, input bit ordy);
    resetN = rst_n; bus.instrValid = vld; bus.instr = ins; bus.outReady = ordy;
    @(posedge clock);
    model_edge(rst_n, vld, ins, ordy);
    @(negedge clock);
    check_all();
  endtask

  task automatic put(input logic [7:0] b, input bit ordy);
    bit rdy;
    for (int k = 0; k < 20; k++) begin
      rdy = !m_wait_exec && !m_wait_out;
      step(1, 1, b, ordy);
      if (rdy) return;
    end
    tests_run++; tests_failed++;
    $display("FAIL put_timeout: byte %h not accepted within 20 cycles", b);
  endtask

  task automatic idle(input bit ordy);
    step(1, 0, 8'($urandom), ordy);
  endtask

  initial begin
    model_reset();
    resetN = 0; bus.instrValid = 0; bus.instr = 8'h00; bus.outReady = 0;
    @(negedge clock);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h44, 1);
    chk("lit_rst_ready", {7'b0, bus.instrReady}, 8'h00);
    chk("lit_rst_a", bus.aluOperandA, 8'h00);

    // LDI A 5, LDI B 3, ADD, OUT
    put(8'h00, 1); put(8'h05, 1); put(8'h01, 1); put(8'h03, 1);
    put(8'h44, 1);
    chk("lit_add_pre_a", bus.aluOperandA, 8'h05);
    chk("lit_add_op", {5'b0, bus.aluOpcode}, 8'h04);
    chk("lit_add_busy", {7'b0, bus.instrReady}, 8'h00);
    idle(1);
    chk("lit_add_a", bus.aluOperandA, 8'h08);
    chk("lit_add_ready", {7'b0, bus.instrReady}, 8'h01);
    put(8'h80, 1);
    chk("lit_out_valid", {7'b0, bus.outValid}, 8'h01);
    chk("lit_out_data", bus.outData, 8'h08);
    chk("lit_out_flags", {6'b0, bus.zero, bus.negative}, 8'h00);
    idle(1);
    chk("lit_out_done", {7'b0, bus.outValid}, 8'h00);

    // SUB 3-5, then 7F+1
    put(8'h00, 1); put(8'h03, 1); put(8'h01, 1); put(8'h05, 1); put(8'h45, 1); idle(1);
    chk("lit_sub_a", bus.aluOperandA, 8'hFE);
    chk("lit_sub_neg", {7'b0, bus.negative}, 8'h01);
    put(8'h00, 1); put(8'h7F, 1); put(8'h01, 1); put(8'h01, 1); put(8'h44, 1); idle(1);
    chk("lit_ovf_a", bus.aluOperandA, 8'h80);
    chk("lit_ovf_flags", {6'b0, bus.zero, bus.negative}, 8'h01);

    // AND to zero, then NOR(0x00, 0x0F)
    put(8'h00, 1); put(8'hF0, 1); put(8'h01, 1); put(8'h0F, 1); put(8'h40, 1); idle(1);
    chk("lit_and_a", bus.aluOperandA, 8'h00);
    chk("lit_and_zero", {7'b0, bus.zero}, 8'h01);
    put(8'h43, 1); idle(1);
    chk("lit_nor_a", bus.aluOperandA, 8'hF0);
    chk("lit_nor_flags", {6'b0, bus.zero, bus.negative}, 8'h01);

    // Illegal bytes
    foreach (legal_tab[i]) if (i < 4) begin
      logic [7:0] bad;
      case (i)
        0: bad = 8'h46;
        1: bad = 8'h48;
        2: bad = 8'h81;
        default: bad = 8'hC1;
      endcase
      put(bad, 1);
      chk("lit_illegal", {7'b0, bus.illegal}, 8'h01);
      chk("lit_illegal_ready", {7'b0, bus.instrReady}, 8'h01);
      chk("lit_illegal_a", bus.aluOperandA, 8'hF0);
    end
    idle(1);
    chk("lit_illegal_drop", {7'b0, bus.illegal}, 8'h00);

    // OUT with outReady held low
    put(8'h80, 0);
    for (int k = 0; k < 5; k++) begin
      idle(0);
      chk("lit_hold_valid", {7'b0, bus.outValid}, 8'h01);
      chk("lit_hold_data", bus.outData, 8'hF0);
    end
    idle(1);
    chk("lit_hold_release", {7'b0, bus.instrReady}, 8'h01);

    // Reset while waiting for an immediate
    put(8'h00, 1);
    step(0, 1, 8'h33, 1);
    chk("lit_rst_imm_a", bus.aluOperandA, 8'h00);
    put(8'h80, 0);
    chk("lit_rst_imm_out", {7'b0, bus.outValid}, 8'h01);
    chk("lit_rst_imm_data", bus.outData, 8'h00);
    idle(1);

    // Reset during OUT
    put(8'h00, 1); put(8'h5A, 1); put(8'h80, 0);
    chk("lit_rst_out_data", bus.outData, 8'h5A);
    step(0, 0, 8'h00, 0);
    chk("lit_rst_out_valid", {7'b0, bus.outValid}, 8'h00);
    idle(0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ins;
      ins = ($urandom_range(0, 1) == 1) ? legal_tab[$urandom_range(0, 9)] : 8'($urandom);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, ins, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller that sits directly upstream of the 8-bit ALU. It accepts instruction bytes over a valid/ready handshake and decodes them. It owns the two operand registers A and B and drives the ALU's opcode and operand inputs. It writes the combinational ALU result back into A, keeps zero/negative flags, and presents A to a downstream consumer on request.

## Interface
- Parameters: none; datapath fixed at 8 bits, two's complement.
- `clock`  in  1  single clock; all state updates on rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `instr`  in  8  instruction or immediate byte.
- `instrValid`  in  1  `instr` valid.
- `instrReady`  out  1  block accepts `instr` this cycle; transfer on `instrValid && instrReady`.
- `aluOpcode`  out  3  registered opcode to ALU.
- `aluOperandA`  out  8  register A, to ALU.
- `aluOperandB`  out  8  register B, to ALU.
- `aluResult`  in  8  combinational ALU result.
- `outData`  out  8  copy of A for the downstream consumer.
- `outValid`  out  1  `outData` valid.
- `outReady`  in  1  downstream accepts; transfer on `outValid && outReady`.
- `zero`  out  1  last ALU writeback was 0x00.
- `negative`  out  1  bit 7 of last ALU writeback.
- `illegal`  out  1  one-cycle pulse on an undefined instruction.

## Operation
- Instruction format: `[7:6]` mode.
  - 00 LDI: `[5:1]`=0; `[0]` selects destination, 0=A, 1=B. The next accepted byte is the immediate.
  - 01 ALU: `[5:3]`=000; `[2:0]` op. 000 AND, 001 OR, 010 NAND, 011 NOR, 100 ADD, 101 SUB (A−B). A ← f(A,B).
  - 10 OUT: `[5:0]`=0; present A on `outData`.
  - 11 NOP: `[5:0]`=0.
- Illegal instruction: any nonzero reserved field, or ALU op 110/111.
  - `illegal` pulses 1 the cycle after acceptance.
  - No register or flag change; state stays FETCH.
- FSM states: FETCH, IMM, EXEC, OUT.
  - FETCH: `instrReady`=1. On accept, decode and go: LDI→IMM (latch dest bit), ALU→EXEC (latch `aluOpcode`), OUT→OUT (latch `outData`=A), NOP/illegal→FETCH.
  - IMM: `instrReady`=1. The accepted byte is written to the latched destination, then →FETCH. The byte is never decoded. Flags unchanged.
  - EXEC: `instrReady`=0. At end of cycle: A ← `aluResult`, `zero` ← (`aluResult`==0), `negative` ← `aluResult[7]`, then →FETCH.
  - OUT: `instrReady`=0, `outValid`=1. `outData` holds stable until handshake. On `outReady`, →FETCH. `outReady` already high on first OUT cycle completes in that cycle.
- `instrReady` and `outValid` are decoded from state only. They never depend combinationally on `instrValid` or `outReady`.
- `aluOperandA`/`aluOperandB` are the A/B registers themselves; no extra staging.
- Arithmetic is 8-bit wrap-around; no carry or overflow is kept.
- Flags update only on ALU writeback. LDI and OUT never touch them.
- Reset values: A=0x00, B=0x00, state FETCH, `aluOpcode`=000, `outData`=0x00, `outValid`=0, `zero`=0, `negative`=0, `illegal`=0.
- `instrReady`=0 while `resetN`=0.
- Reset mid-operation: a pending immediate, EXEC writeback or OUT transfer is discarded. The first byte accepted after reset is decoded as an instruction.

## Timing
- ALU instruction accepted at edge E0. `aluOpcode` is valid from E0. A and flags update at E1. `instrReady` is high again after E1.
- Throughput is 1 ALU op per 2 cycles.
- Back-to-back ALU ops read the updated A; no hazard exists.
- LDI: 2 accepted bytes. Destination is updated at the edge accepting the immediate; the next instruction is accepted the following cycle.
- OUT: `outValid` rises the cycle after acceptance and stays high until the handshake edge. The minimum OUT→next-instruction gap is 1 cycle.
- NOP/illegal: 1 cycle, no bubble.
- Gaps in `instrValid` stall FETCH/IMM indefinitely with no state change.

## Test plan
- LDI A 0x05 (0x00,0x05), LDI B 0x03 (0x01,0x03), ADD 0x44, OUT 0x80 with `outReady`=1 → `outData`=0x08, `zero`=0, `negative`=0; A updated exactly 1 cycle after ADD accept.
- A=0x03, B=0x05, SUB 0x45 → A=0xFE, `negative`=1. Then A=0x7F, B=0x01, ADD → A=0x80, `negative`=1, `zero`=0.
- A=0xF0, B=0x0F, AND 0x40 → A=0x00, `zero`=1. NOR 0x43 on those values → A=0xF0, `zero`=0, `negative`=1.
- Illegal bytes 0x46, 0x48, 0x81, 0xC1 → each gives a single-cycle `illegal` pulse; A, B and flags unchanged; `instrReady` never deasserts.
- OUT with `outReady` low for 5 cycles → `outValid`=1 and `outData` constant, `instrReady`=0 throughout. Raise `outReady` → transfer completes, FETCH next cycle.
- Reset mid-operation → all outputs at reset values after the reset edge:
  - Assert `resetN`=0 in IMM (after 0x00), release, send 0x80 → byte decoded as OUT, `outData`=0x00.
  - Repeat with reset during OUT → `outValid` drops at the reset edge.
